// File: rtl/riscv_dmem_ctrl.sv
// RV32I data-memory responder: accepts core load/store requests, aligns them onto
// a synchronous single-port SRAM and returns extended load data or an error flag.
module riscv_dmem_ctrl #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int MEM_LATENCY = 1,
    localparam int AW = $clog2(DEPTH_WORDS),
    localparam int NB = XLEN / 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_we,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [XLEN-1:0] i_req_wdata,
    input  logic [NB-1:0]   i_req_byte_sel,
    input  logic [2:0]      i_req_funct3,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [XLEN-1:0] o_rsp_rdata,
    output logic            o_rsp_err,
    output logic            o_mem_en,
    output logic [NB-1:0]   o_mem_we,
    output logic [AW-1:0]   o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    input  logic [XLEN-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t          state, next_state;
    logic            we_q;
    logic [AW+1:0]   addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [NB-1:0]   sel_q;
    logic            unsigned_q;
    logic [2:0]      wait_cnt;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;

    logic            sel_byte, sel_half, sel_word;
    logic            misaligned, out_of_range, bad_req;
    logic [XLEN-1:0] shifted, load_ext;
    logic            unused_funct3;

    assign unused_funct3 = ^i_req_funct3[1:0];

    assign sel_byte     = (i_req_byte_sel == NB'(1));
    assign sel_half     = (i_req_byte_sel == NB'(3));
    assign sel_word     = (i_req_byte_sel == NB'(15));
    assign misaligned   = (sel_half && i_req_addr[0]) || (sel_word && (i_req_addr[1:0] != 2'b00));
    assign out_of_range = (i_req_addr >> 2) >= XLEN'(DEPTH_WORDS);
    assign bad_req      = !(sel_byte || sel_half || sel_word) || misaligned || out_of_range;

    // Bring the addressed lane down to bit 0, then sign- or zero-extend by size.
    assign shifted = i_mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = shifted;
        if (sel_q == NB'(1)) begin
            load_ext = {{(XLEN-8){~unsigned_q & shifted[7]}}, shifted[7:0]};
        end else if (sel_q == NB'(3)) begin
            load_ext = {{(XLEN-16){~unsigned_q & shifted[15]}}, shifted[15:0]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        o_mem_en    = 1'b0;
        o_mem_we    = '0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        case (state)
            IDLE: begin
                if (i_req_valid) begin
                    next_state = bad_req ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                o_mem_en   = 1'b1;
                o_mem_addr = addr_q[2 +: AW];
                if (we_q) begin
                    o_mem_we    = sel_q << addr_q[1:0];
                    o_mem_wdata = wdata_q << {addr_q[1:0], 3'b000};
                    next_state  = RESP;
                end else begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 3'd0) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        // Reset aborts at once: no SRAM strobe even in the cycle it is asserted.
        if (i_rst) begin
            next_state  = IDLE;
            o_mem_en    = 1'b0;
            o_mem_we    = '0;
            o_mem_addr  = '0;
            o_mem_wdata = '0;
        end
    end

    // Request capture, latency countdown and response data registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            sel_q      <= '0;
            unsigned_q <= 1'b0;
            wait_cnt   <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        we_q       <= i_req_we;
                        addr_q     <= i_req_addr[AW+1:0];
                        wdata_q    <= i_req_wdata;
                        sel_q      <= i_req_byte_sel;
                        unsigned_q <= i_req_funct3[2];
                        rdata_q    <= '0;
                        err_q      <= bad_req;
                    end
                end
                ACCESS: wait_cnt <= 3'(MEM_LATENCY - 1);
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        rdata_q <= load_ext;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_req_ready = (state == IDLE) || i_rst;
    assign o_rsp_valid = (state == RESP) && !i_rst;
    assign o_rsp_rdata = rdata_q;
    assign o_rsp_err   = err_q;

endmodule

// File: doc/riscv_dmem_ctrl.md
Name: riscv_dmem_ctrl

Overview:
- Data-memory responder for the RV32I core. It consumes the load/store requests the core issues (write enable, LSB-justified byte select, funct3, address, store data).
- It drives a synchronous single-port SRAM: byte-lane alignment, lane write strobes, load extraction with sign/zero extension, misalignment and range checking.
- It sits between the core's dmem port and the data SRAM, using a valid/ready request handshake and a valid/ready response handshake.

Parameters:
- XLEN, 32, data/address width (only 32 supported).
- DEPTH_WORDS, 1024, SRAM depth in XLEN-bit words (power of 2).
- MEM_LATENCY, 1, SRAM read latency in cycles (1..4).

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  synchronous active-high reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  controller can accept a request
- i_req_we  in  1  1=store, 0=load
- i_req_addr  in  XLEN  byte address
- i_req_wdata  in  XLEN  store data, LSB-justified
- i_req_byte_sel  in  XLEN/8  LSB-justified size mask: 0001=byte, 0011=half, 1111=word
- i_req_funct3  in  3  load funct3; bit2=1 means unsigned (LBU/LHU)
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  consumer accepts response
- o_rsp_rdata  out  XLEN  extended load data (0 for stores/errors)
- o_rsp_err  out  1  misaligned, illegal size, or out-of-range access
- o_mem_en  out  1  SRAM access strobe
- o_mem_we  out  XLEN/8  per-lane write strobes
- o_mem_addr  out  log2(DEPTH_WORDS)  SRAM word address
- o_mem_wdata  out  XLEN  lane-shifted store data
- i_mem_rdata  in  XLEN  SRAM read data

Behaviour:
- Interface:
  - One clock, i_clk.
  - Reset i_rst is synchronous and active-high.
- Reset:
  - State goes to IDLE.
  - o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, o_mem_en=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0.
  - o_req_ready=1 (IDLE), but requests are ignored while i_rst=1.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid, latch all request fields.
  - Next state is RESP with err=1 if the request is bad, else ACCESS.
- Bad request, any of:
  - byte_sel not in {0001, 0011, 1111};
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[XLEN-1:2] >= DEPTH_WORDS.
- ACCESS (one cycle):
  - o_mem_en=1, o_mem_addr=addr[2+:log2(DEPTH_WORDS)].
  - Store: o_mem_we = byte_sel << addr[1:0]; o_mem_wdata = wdata << (8*addr[1:0]); next state RESP.
  - Load: o_mem_we=0; next state WAIT.
- WAIT:
  - Counts MEM_LATENCY cycles; o_mem_en=0.
  - In the last WAIT cycle, sample i_mem_rdata.
  - Shift right by 8*addr[1:0] and mask to the byte_sel width.
  - Sign-extend from bit 7 (byte) or bit 15 (half) unless funct3[2]=1, in which case zero-extend. Word loads pass through unchanged.
  - Next state RESP.
- RESP:
  - o_rsp_valid=1; rdata/err held stable until i_rsp_ready=1.
  - The handshake cycle returns to IDLE; o_req_ready reasserts the following cycle (no back-to-back accept in RESP).
- Latency from accept cycle T (i_rsp_ready tied 1):
  - Error: rsp_valid at T+1.
  - Store: mem_en at T+1, rsp_valid at T+2.
  - Load: mem_en at T+1, rsp_valid at T+2+MEM_LATENCY.
- o_mem_en is high in exactly one cycle per good request and never for errored requests. o_mem_we is 0 whenever o_mem_en=0.
- Reset mid-operation (any state):
  - Abort immediately; no further mem_en.
  - The pending response is dropped and never presented.
- i_req_valid while o_req_ready=0: ignored. The requester must hold the request until accepted.
- Store response: o_rsp_rdata=0, err=0.

Test Plan:
- Word store then load: store addr 0x10, data 0xDEADBEEF, sel 1111 -> o_mem_we=1111, o_mem_addr=4, rsp at T+2. Load addr 0x10 -> rdata=0xDEADBEEF at T+3 (MEM_LATENCY=1).
- Byte lanes: SB 0x000000A5 to addr 0x13 -> o_mem_we=1000, o_mem_wdata=0xA5000000. LB from 0x13 -> 0xFFFFFFA5; LBU -> 0x000000A5.
- Halfword: SH 0x00008001 to 0x22 -> we=1100, wdata=0x80010000. LH -> 0xFFFF8001; LHU -> 0x00008001.
- Errors, each giving err=1, rdata=0, no mem_en, rsp at T+1:
  - LW at 0x02;
  - LH at 0x05;
  - byte_sel 0111;
  - addr 0x00001000 with DEPTH_WORDS=1024.
- Backpressure: hold i_rsp_ready=0 for 5 cycles after a load -> rsp_valid/rdata stable, o_req_ready=0, new i_req_valid ignored. Release -> IDLE next cycle, then accept.
- Reset mid-load: assert i_rst during WAIT -> next cycle IDLE, o_rsp_valid=0, no response ever issued. Following request behaves normally.
